hilo_muldiv_unit: RTL
=====================

HILO_MULDIV_UNIT -- requirements
Module: hilo_muldiv_unit

Interface
REQ-001 SHALL have parameter HILO_RESET, default 32'h00000000, the reset value of HI and LO.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset: asynchronous assert, active-low.
REQ-004 SHALL have port start  input  1  request strobe; sampled on the rising edge of clk.
REQ-005 SHALL have port op  input  3  operation code: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6-7 reserved.
REQ-006 SHALL have port rs_data  input  32  multiplicand/dividend, or MTHI/MTLO source.
REQ-007 SHALL have port rt_data  input  32  multiplier/divisor.
REQ-008 SHALL have port busy  output  1  high while an iterative operation is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse when HI/LO have just been updated.
REQ-010 SHALL have port hi  output  32  registered HI value, read directly by MFHI.
REQ-011 SHALL have port lo  output  32  registered LO value, read directly by MFLO.

Function
REQ-012 SHALL accept a request when start=1, busy=0 and op is 0-5; a request with op 6-7 SHALL be ignored with no state change.
REQ-013 SHALL ignore start while busy=1; the operation in progress and its operands SHALL be unaffected.
REQ-014 SHALL latch rs_data, rt_data and op on the accept edge; later input changes SHALL have no effect on the result.
REQ-015 SHALL implement FSM states IDLE, RUN and FIX: IDLE->RUN on accepting ops 0-3; RUN for exactly 32 cycles, counted by a 5-bit counter; RUN->FIX when the counter wraps; FIX->IDLE unconditionally.
REQ-016 SHALL hold busy=1 in RUN and FIX, and busy=0 in IDLE.
REQ-017 SHALL multiply by 32-step shift-add and divide by 32-step restoring division on operand magnitudes; signed ops SHALL convert operands to magnitudes on accept and apply the sign correction in FIX.
REQ-018 SHALL write HI/LO and pulse done on the FIX->IDLE edge, so that results are visible 33 cycles after the accept edge.
REQ-019 SHALL leave HI/LO unchanged from the accept edge until that write.
REQ-020 MULT/MULTU SHALL set HI = product[63:32] and LO = product[31:0], using a signed or unsigned 64-bit product respectively.
REQ-021 DIV/DIVU SHALL set LO = quotient and HI = remainder; signed quotients truncate toward zero and the remainder takes the dividend's sign.
REQ-022 Division by zero SHALL set LO=32'hFFFFFFFF and HI=rs_data, for both signed and unsigned division.
REQ-023 DIV of 32'h80000000 by 32'hFFFFFFFF SHALL set LO=32'h80000000 and HI=0.
REQ-024 MTHI/MTLO SHALL write rs_data into HI or LO respectively on the accept edge, leave the other register untouched, pulse done the next cycle, and never assert busy.
REQ-025 done SHALL be 0 in every cycle other than those defined in REQ-018, REQ-024 and REQ-033.

Reset
REQ-026 While rst_n=0, the block SHALL hold FSM=IDLE, counter=0, busy=0, done=0 and hi=lo=HILO_RESET.
REQ-027 rst_n falling during RUN or FIX SHALL abort the operation immediately, without writing HI/LO and without a done pulse.
REQ-028 The first request SHALL be accepted on the first rising edge with rst_n=1.

Configuration
REQ-029 SHALL use the macro HILO_MULDIV_FAST_MULT_EN.
REQ-030 When HILO_MULDIV_FAST_MULT_EN is defined, MULT/MULTU SHALL use a combinational 64-bit multiplier.
REQ-031 With the macro defined, HI/LO SHALL be written on the accept edge.
REQ-032 With the macro defined, MULT/MULTU SHALL never assert busy.
REQ-033 With the macro defined, done SHALL pulse in the cycle after the accept edge.
REQ-034 With the macro defined, DIV/DIVU SHALL be unchanged.
REQ-035 When HILO_MULDIV_FAST_MULT_EN is undefined, all multiplies SHALL follow REQ-015 to REQ-018.

Verification
REQ-036 MULTU 32'hFFFFFFFF x 32'hFFFFFFFF -> HI=32'hFFFFFFFE, LO=32'h00000001, done pulse 33 cycles after accept (1 cycle with the macro).
REQ-037 MULT -3 x 5 -> HI=32'hFFFFFFFF, LO=32'hFFFFFFF1; then DIV -7/2 -> LO=32'hFFFFFFFD, HI=32'hFFFFFFFF; then DIVU 7/2 -> LO=3, HI=1.
REQ-038 DIVU 32'h12345678/0 -> LO=32'hFFFFFFFF, HI=32'h12345678; DIV 32'h80000000/32'hFFFFFFFF -> LO=32'h80000000, HI=0.
REQ-039 DIVU started, then start with MULTU at cycle 5 while busy -> the DIVU result is unaffected and only one done pulse occurs.
REQ-040 rst_n=0 at cycle 10 of a DIV -> busy=0 and hi=lo=HILO_RESET immediately, with no done pulse; a new request after release completes normally.
REQ-041 With hi=lo=0, MTHI 32'hDEADBEEF -> hi=32'hDEADBEEF and lo=0 the next cycle with done=1 and busy=0; op=6 with start=1 -> no change.

Source files
------------

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit -- HI/LO multiply/divide unit.
// Iterative 32-step shift-add multiplier and 32-step restoring divider that
// work on operand magnitudes; signs are applied in a final fix-up state.
// MTHI/MTLO write HI/LO directly on the accept edge.
// Optional feature macro: HILO_MULDIV_FAST_MULT_EN -- when defined, MULT/MULTU
// use a combinational 64-bit multiplier and complete on the accept edge.
module hilo_muldiv_unit #(
    parameter logic [31:0] HILO_RESET = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    // Magnitude of a value, treating it as two's complement only when sgn is set.
    function automatic logic [31:0] abs32(input logic [31:0] v, input logic sgn);
        logic [31:0] res;
        if (sgn && v[31]) begin
            res = 32'd0 - v;
        end else begin
            res = v;
        end
        return res;
    endfunction

    state_t      r_state;
    state_t      w_state_nxt;
    logic [4:0]  r_cnt;
    logic [63:0] r_acc;      // mult: {partial product, multiplier}; div: {remainder, quotient}
    logic [31:0] r_opnd;     // mult: multiplicand magnitude; div: divisor magnitude
    logic [31:0] r_rs;       // original dividend, needed for divide-by-zero HI
    logic        r_is_mul;
    logic        r_neg_q;    // negate product / quotient in FIX
    logic        r_neg_r;    // negate remainder in FIX
    logic        r_divz;
    logic        r_busy;
    logic        r_done;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_accept;
    logic        w_iter;
    logic        w_done_nxt;
    logic        w_sgn;
    logic        w_rs_neg;
    logic        w_rt_neg;
    logic [32:0] w_mul_sum;
    logic [32:0] w_rem_sh;
    logic        w_div_ge;
    logic [31:0] w_div_sub;
    logic [63:0] w_acc_step;
    logic [63:0] w_prod;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;

`ifdef HILO_MULDIV_FAST_MULT_EN
    logic [63:0] w_fast_prod;

    // Single-cycle 64-bit product for MULT (signed) and MULTU (unsigned).
    always_comb begin
        if (op == OP_MULT) begin
            w_fast_prod = $signed({{32{rs_data[31]}}, rs_data}) * $signed({{32{rt_data[31]}}, rt_data});
        end else begin
            w_fast_prod = {32'd0, rs_data} * {32'd0, rt_data};
        end
    end
`endif

    // Request decode: legal op, signedness, and whether it needs the iterative path.
    always_comb begin
        w_accept = start && (op <= OP_MTLO);
        w_sgn    = (op == OP_MULT) || (op == OP_DIV);
        w_rs_neg = w_sgn && rs_data[31];
        w_rt_neg = w_sgn && rt_data[31];
`ifdef HILO_MULDIV_FAST_MULT_EN
        w_iter   = (op == OP_DIV) || (op == OP_DIVU);
`else
        w_iter   = (op[2] == 1'b0);
`endif
    end

    // FSM next state and done request (done is registered below).
    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_iter) begin
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (r_cnt == 5'd31) begin
                    w_state_nxt = ST_FIX;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_FIX: begin
                w_state_nxt = ST_IDLE;
                w_done_nxt  = 1'b1;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // One shift-add or restoring-divide step on the shared accumulator.
    always_comb begin
        w_mul_sum = {1'b0, r_acc[63:32]} + {1'b0, r_opnd};
        w_rem_sh  = r_acc[63:31];
        w_div_ge  = (w_rem_sh >= {1'b0, r_opnd});
        w_div_sub = w_rem_sh[31:0] - r_opnd;
        if (r_is_mul) begin
            if (r_acc[0]) begin
                w_acc_step = {w_mul_sum, r_acc[31:1]};
            end else begin
                w_acc_step = {1'b0, r_acc[63:1]};
            end
        end else if (w_div_ge) begin
            w_acc_step = {w_div_sub, r_acc[30:0], 1'b1};
        end else begin
            w_acc_step = {w_rem_sh[31:0], r_acc[30:0], 1'b0};
        end
    end

    // Sign correction and special cases applied in FIX.
    always_comb begin
        w_prod = r_neg_q ? (64'd0 - r_acc) : r_acc;
        w_quo  = r_neg_q ? (32'd0 - r_acc[31:0]) : r_acc[31:0];
        w_rem  = r_neg_r ? (32'd0 - r_acc[63:32]) : r_acc[63:32];
        if (r_is_mul) begin
            w_res_hi = w_prod[63:32];
            w_res_lo = w_prod[31:0];
        end else if (r_divz) begin
            w_res_hi = r_rs;
            w_res_lo = 32'hFFFF_FFFF;
        end else begin
            w_res_hi = w_rem;
            w_res_lo = w_quo;
        end
    end

    // FSM state register and registered busy flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
        end
    end

    // Operand capture, iteration, HI/LO update and done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= 5'd0;
            r_acc    <= 64'd0;
            r_opnd   <= 32'd0;
            r_rs     <= 32'd0;
            r_is_mul <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_divz   <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= HILO_RESET;
            r_lo     <= HILO_RESET;
        end else begin
            r_done <= w_done_nxt;
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= 5'd0;
                    if (w_accept) begin
                        case (op)
                            OP_MTHI: r_hi <= rs_data;
                            OP_MTLO: r_lo <= rs_data;
`ifdef HILO_MULDIV_FAST_MULT_EN
                            OP_MULT, OP_MULTU: begin
                                r_hi <= w_fast_prod[63:32];
                                r_lo <= w_fast_prod[31:0];
                            end
`endif
                            default: begin
                                // Remaining accepted ops are the iterative ones.
                                r_is_mul <= (op == OP_MULT) || (op == OP_MULTU);
                                r_neg_q  <= w_rs_neg ^ w_rt_neg;
                                r_neg_r  <= w_rs_neg;
                                r_divz   <= (rt_data == 32'd0);
                                r_rs     <= rs_data;
                                if ((op == OP_MULT) || (op == OP_MULTU)) begin
                                    r_opnd <= abs32(rs_data, w_sgn);
                                    r_acc  <= {32'd0, abs32(rt_data, w_sgn)};
                                end else begin
                                    r_opnd <= abs32(rt_data, w_sgn);
                                    r_acc  <= {32'd0, abs32(rs_data, w_sgn)};
                                end
                            end
                        endcase
                    end
                end
                ST_RUN: begin
                    r_acc <= w_acc_step;
                    r_cnt <= r_cnt + 5'd1;
                end
                ST_FIX: begin
                    r_hi <= w_res_hi;
                    r_lo <= w_res_lo;
                end
                default: begin
                    r_cnt <= 5'd0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
